// File: rtl/block_cipher_cbc_seq_if.sv
// ----------------------------------------------------------------------------
// block_cipher_cbc_seq_if
// Handshake and data bundle for the sequential CBC engine.
//   master : request side (drives start/mode/din/key/iv[/chain], observes
//            busy/done/dout)
//   slave  : engine side
// Signal names carry the engine's point of view (i_ = into the engine,
// o_ = out of the engine).
// Optional: CBC_CHAIN_EN adds i_chain (use last message's final ciphertext
// block as the IV).
// ----------------------------------------------------------------------------
interface block_cipher_cbc_seq_if #(
    parameter int BW = 4,
    parameter int NB = 2
);
    logic              i_start;
    logic              i_mode;
    logic [BW*NB-1:0]  i_din;
    logic [BW-1:0]     i_key;
    logic [BW-1:0]     i_iv;
`ifdef CBC_CHAIN_EN
    logic              i_chain;
`endif
    logic              o_busy;
    logic              o_done;
    logic [BW*NB-1:0]  o_dout;

    modport master (
        output i_start, i_mode, i_din, i_key, i_iv,
`ifdef CBC_CHAIN_EN
        output i_chain,
`endif
        input  o_busy, o_done, o_dout
    );

    modport slave (
        input  i_start, i_mode, i_din, i_key, i_iv,
`ifdef CBC_CHAIN_EN
        input  i_chain,
`endif
        output o_busy, o_done, o_dout
    );
endinterface

// File: rtl/block_cipher_cbc_seq.sv
// ----------------------------------------------------------------------------
// block_cipher_cbc_seq
// Sequential CBC encrypt/decrypt engine over a keyed toy block cipher
//   E(x) = rotl1(x ^ key), D(y) = rotr1(y) ^ key
// One BW-bit block is processed per clock; a message is NB blocks with
// block 0 in the most significant position of din/dout.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-high
//   bus  - block_cipher_cbc_seq_if.slave
//          i_start/i_mode/i_din/i_key/i_iv[/i_chain] captured on start
//          o_busy  high while blocks are processed
//          o_done  one-cycle pulse, o_dout valid
//          o_dout  result, held until the next message completes
//
// Optional feature macro: CBC_CHAIN_EN
//   Adds i_chain and a last-ciphertext register; chain=1 at start replaces
//   the IV with the previous message's final ciphertext block.
// ----------------------------------------------------------------------------
module block_cipher_cbc_seq #(
    parameter int BW = 4,
    parameter int NB = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    block_cipher_cbc_seq_if.slave bus
);
    localparam int            IW       = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [IW-1:0]     r_idx;
    logic              r_mode;
    logic [BW*NB-1:0]  r_din;
    logic [BW*NB-1:0]  r_res;
    logic [BW*NB-1:0]  r_dout;
    logic [BW-1:0]     r_key;
    logic [BW-1:0]     r_chain_val;    // c_{i-1}
`ifdef CBC_CHAIN_EN
    logic [BW-1:0]     r_last;         // final ciphertext block of last message
`endif

    logic              w_capture;
    logic              w_last_blk;
    int                w_pos;
    logic [BW-1:0]     w_blk_in;
    logic [BW-1:0]     w_enc_x;
    logic [BW-1:0]     w_blk_out;
    logic [BW-1:0]     w_chain_next;
    logic [BW-1:0]     w_c_init;
    logic [BW*NB-1:0]  w_res_next;

    // DONE accepts a new start exactly like IDLE; only RUN ignores it.
    assign w_capture  = bus.i_start && (r_state != RUN);
    assign w_last_blk = (r_idx == LAST_IDX);

`ifdef CBC_CHAIN_EN
    assign w_c_init = bus.i_chain ? r_last : bus.i_iv;
`else
    assign w_c_init = bus.i_iv;
`endif

    // ------------------------------------------------------------------
    // Datapath for the current block
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        w_pos        = (NB - 1 - int'(r_idx)) * BW;
        w_blk_in     = r_din[w_pos +: BW];
        w_enc_x      = w_blk_in ^ r_chain_val ^ r_key;
        w_blk_out    = {w_enc_x[BW-2:0], w_enc_x[BW-1]};
        w_chain_next = w_blk_out;
        if (r_mode) begin
            // Decrypt: the chaining value is the ciphertext *input* block.
            w_blk_out    = {w_blk_in[0], w_blk_in[BW-1:1]} ^ r_key ^ r_chain_val;
            w_chain_next = w_blk_in;
        end
        w_res_next               = r_res;
        w_res_next[w_pos +: BW]  = w_blk_out;
    end

    // ------------------------------------------------------------------
    // FSM: state register + next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.i_start) w_state_next = RUN;
            RUN:     if (w_last_blk)  w_state_next = DONE;
            DONE:    w_state_next = bus.i_start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, per-block processing, result publication
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_mode      <= 1'b0;
            r_din       <= '0;
            r_res       <= '0;
            r_dout      <= '0;
            r_key       <= '0;
            r_chain_val <= '0;
`ifdef CBC_CHAIN_EN
            r_last      <= '0;
`endif
        end else if (w_capture) begin
            r_idx       <= '0;
            r_mode      <= bus.i_mode;
            r_din       <= bus.i_din;
            r_key       <= bus.i_key;
            r_chain_val <= w_c_init;
            r_res       <= '0;
        end else if (r_state == RUN) begin
            r_res       <= w_res_next;
            r_chain_val <= w_chain_next;
            if (w_last_blk) begin
                // Only a completed message reaches dout.
                r_dout <= w_res_next;
`ifdef CBC_CHAIN_EN
                r_last <= w_chain_next;
`endif
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign bus.o_busy = (r_state == RUN);
    assign bus.o_done = (r_state == DONE);
    assign bus.o_dout = r_dout;

endmodule

// File: tb/tb_block_cipher_cbc_seq.sv
// ----------------------------------------------------------------------------
// tb_block_cipher_cbc_seq
// Main instance BW=4/NB=2 is checked every cycle against a message-level
// model (a cycles-remaining counter plus a whole-message CBC function).
// Two extra instances cover BW=8/NB=4 round trips and NB=1 latency.
// ----------------------------------------------------------------------------
module tb_block_cipher_cbc_seq;
    localparam int BW = 4;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    block_cipher_cbc_seq_if #(.BW(BW), .NB(NB)) bus  ();
    block_cipher_cbc_seq_if #(.BW(8),  .NB(4))  bus8 ();
    block_cipher_cbc_seq_if #(.BW(4),  .NB(1))  bus1 ();

    block_cipher_cbc_seq #(.BW(BW), .NB(NB)) dut  (.clk(clk), .rst(rst), .bus(bus));
    block_cipher_cbc_seq #(.BW(8),  .NB(4))  dut8 (.clk(clk), .rst(rst), .bus(bus8));
    block_cipher_cbc_seq #(.BW(4),  .NB(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-message CBC straight from the cipher definitions.
    function automatic logic [63:0] cbc_model(input bit dec, input logic [63:0] d,
                                              input int bw, input int nb,
                                              input logic [63:0] k, input logic [63:0] c_prev);
        logic [63:0] mask, prev, blk, t, r, res;
        mask = (64'd1 << bw) - 64'd1;
        prev = c_prev & mask;
        res  = '0;
        for (int i = 0; i < nb; i++) begin
            blk = (d >> (bw * (nb - 1 - i))) & mask;
            if (!dec) begin
                t    = (blk ^ prev ^ k) & mask;
                r    = ((t << 1) | (t >> (bw - 1))) & mask;
                prev = r;
            end else begin
                t    = ((blk >> 1) | (blk << (bw - 1))) & mask;
                r    = (t ^ k ^ prev) & mask;
                prev = blk;
            end
            res = res | (r << (bw * (nb - 1 - i)));
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Message-level reference for the main instance
    // ------------------------------------------------------------------
    int          m_rem;       // cycles until the in-flight message completes
    bit          m_done;
    logic [63:0] m_dout, m_pend, m_pend_din, m_last, m_cprev;
    bit          m_pend_dec;
    bit          cmp_en = 1'b0;

    always_comb begin
        m_cprev = 64'(bus.i_iv);
`ifdef CBC_CHAIN_EN
        if (bus.i_chain) m_cprev = m_last;
`endif
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_dout <= '0;
            m_last <= '0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done <= 1'b1;
                m_dout <= m_pend;
                m_last <= m_pend_dec ? (m_pend_din & 64'hF) : (m_pend & 64'hF);
            end
        end else begin
            m_done <= 1'b0;
            if (bus.i_start) begin
                m_pend     <= cbc_model(bus.i_mode, 64'(bus.i_din), BW, NB, 64'(bus.i_key), m_cprev);
                m_pend_dec <= bus.i_mode;
                m_pend_din <= 64'(bus.i_din);
                m_rem      <= NB;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_busy", 64'(bus.o_busy), 64'(m_rem > 0));
            check("cmp_done", 64'(bus.o_done), 64'(m_done));
            check("cmp_dout", 64'(bus.o_dout), m_dout);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit md, input logic [7:0] d, input bit ch,
                        input logic [3:0] k, input logic [3:0] v);
        bus.i_start = 1'b1;
        bus.i_mode  = md;
        bus.i_din   = d;
        bus.i_key   = k;
        bus.i_iv    = v;
`ifdef CBC_CHAIN_EN
        bus.i_chain = ch;
`else
        if (ch) bus.i_start = 1'b1;
`endif
        step();
        bus.i_start = 1'b0;
    endtask

    // Called just after the start edge; returns edges until done is seen.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat = 0;
        busy_cyc = 0;
        while (bus.o_done !== 1'b1 && lat < 50) begin
            if (bus.o_busy) busy_cyc++;
            step();
            lat++;
        end
    endtask

    task automatic directed(input string nm, input bit md, input logic [7:0] d,
                            input bit ch, input logic [7:0] exp);
        int lat, bc;
        send(md, d, ch, 4'd11, 4'd9);
        // Captured already: these must not affect the message.
        bus.i_din = 8'($urandom);
        bus.i_key = 4'($urandom);
        bus.i_iv  = 4'($urandom);
        wait_done(lat, bc);
        check({nm, "_latency"}, 64'(lat), 64'(NB));
        check({nm, "_busy_cycles"}, 64'(bc), 64'(NB));
        check({nm, "_dout"}, 64'(bus.o_dout), 64'(exp));
        step();
        check({nm, "_done_pulse"}, 64'(bus.o_done), 64'd0);
    endtask

    task automatic run8(input bit md, input logic [31:0] d, output logic [31:0] r, output int lat);
        bus8.i_start = 1'b1;
        bus8.i_mode  = md;
        bus8.i_din   = d;
        bus8.i_key   = 8'hA5;
        bus8.i_iv    = 8'h3C;
        step();
        bus8.i_start = 1'b0;
        lat = 0;
        while (bus8.o_done !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        r = bus8.o_dout;
        step();
    endtask

    task automatic run1(input bit md, input logic [3:0] d, output logic [3:0] r, output int lat);
        bus1.i_start = 1'b1;
        bus1.i_mode  = md;
        bus1.i_din   = d;
        bus1.i_key   = 4'd11;
        bus1.i_iv    = 4'd9;
        step();
        bus1.i_start = 1'b0;
        lat = 0;
        while (bus1.o_done !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        r = bus1.o_dout;
        step();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int          lat, bc;
        logic [31:0] d32, c32, p32;
        logic [3:0]  d4, c4, p4;

        bus.i_start  = 0; bus.i_mode  = 0; bus.i_din  = '0; bus.i_key  = '0; bus.i_iv  = '0;
        bus8.i_start = 0; bus8.i_mode = 0; bus8.i_din = '0; bus8.i_key = '0; bus8.i_iv = '0;
        bus1.i_start = 0; bus1.i_mode = 0; bus1.i_din = '0; bus1.i_key = '0; bus1.i_iv = '0;
`ifdef CBC_CHAIN_EN
        bus.i_chain = 0; bus8.i_chain = 0; bus1.i_chain = 0;
`endif
        #1 rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        cmp_en = 1'b1;

        check("reset_busy", 64'(bus.o_busy), 64'd0);
        check("reset_done", 64'(bus.o_done), 64'd0);
        check("reset_dout", 64'(bus.o_dout), 64'd0);

        // Hand-computed values pin the model itself.
        check("model_enc_0C", cbc_model(1'b0, 64'h0C, 4, 2, 64'd11, 64'd9), 64'h46);
        check("model_enc_FF", cbc_model(1'b0, 64'hFF, 4, 2, 64'd11, 64'd9), 64'hBF);
        check("model_dec_BF", cbc_model(1'b1, 64'hBF, 4, 2, 64'd11, 64'd9), 64'hFF);
        check("model_dec_46", cbc_model(1'b1, 64'h46, 4, 2, 64'd11, 64'd9), 64'h0C);

        directed("enc_0C", 1'b0, 8'h0C, 1'b0, 8'h46);
        directed("enc_FF", 1'b0, 8'hFF, 1'b0, 8'hBF);
        directed("dec_BF", 1'b1, 8'hBF, 1'b0, 8'hFF);
        directed("dec_46", 1'b1, 8'h46, 1'b0, 8'h0C);

        // start pulses and din changes while RUN must be ignored
        send(1'b0, 8'h0C, 1'b0, 4'd11, 4'd9);
        bus.i_start = 1'b1; bus.i_din = 8'h5A; bus.i_key = 4'd3;
        step();
        bus.i_start = 1'b1; bus.i_din = 8'hA7;
        step();
        bus.i_start = 1'b0;
        check("ignore_done", 64'(bus.o_done), 64'd1);
        check("ignore_dout", 64'(bus.o_dout), 64'h46);
        step();
        check("ignore_single_done", 64'(bus.o_done), 64'd0);

`ifdef CBC_CHAIN_EN
        directed("chain_seed",  1'b0, 8'hFF, 1'b0, 8'hBF);
        directed("chain_on",    1'b0, 8'h0C, 1'b1, 8'h8F);
        directed("chain_off",   1'b0, 8'h0C, 1'b0, 8'h46);
`endif

        // reset in the middle of RUN aborts the message
        send(1'b0, 8'hFF, 1'b0, 4'd11, 4'd9);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus.o_busy), 64'd0);
        check("abort_done", 64'(bus.o_done), 64'd0);
        check("abort_dout", 64'(bus.o_dout), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < NB + 3; i++) begin
            check("abort_no_done", 64'(bus.o_done), 64'd0);
            step();
        end

        // back-to-back: second start lands in DONE; done pulses NB+1 edges apart
        send(1'b0, 8'hFF, 1'b0, 4'd11, 4'd9);
        wait_done(lat, bc);
        check("b2b_first_latency", 64'(lat), 64'(NB));
        check("b2b_first_dout", 64'(bus.o_dout), 64'hBF);
        send(1'b1, 8'hBF, 1'b0, 4'd11, 4'd9);
        wait_done(lat, bc);
        check("b2b_done_spacing", 64'(lat + 1), 64'(NB + 1));
        check("b2b_second_dout", 64'(bus.o_dout), 64'hFF);
        step();

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            bus.i_start = ($urandom_range(0, 2) == 0);
            bus.i_mode  = 1'($urandom);
            bus.i_din   = 8'($urandom);
            bus.i_key   = 4'($urandom);
            bus.i_iv    = 4'($urandom);
`ifdef CBC_CHAIN_EN
            bus.i_chain = 1'($urandom);
`endif
            step();
        end
        bus.i_start = 1'b0;
        repeat (NB + 2) step();

        // BW=8, NB=4 round trips
        for (int i = 0; i < 4; i++) begin
            d32 = $urandom;
            run8(1'b0, d32, c32, lat);
            check("w8_enc_latency", 64'(lat), 64'd4);
            check("w8_enc_dout", 64'(c32), cbc_model(1'b0, 64'(d32), 8, 4, 64'hA5, 64'h3C));
            run8(1'b1, c32, p32, lat);
            check("w8_roundtrip", 64'(p32), 64'(d32));
        end

        // NB=1: RUN lasts one cycle
        for (int i = 0; i < 3; i++) begin
            d4 = 4'($urandom);
            run1(1'b0, d4, c4, lat);
            check("nb1_latency", 64'(lat), 64'd1);
            check("nb1_enc_dout", 64'(c4), cbc_model(1'b0, 64'(d4), 4, 1, 64'd11, 64'd9));
            run1(1'b1, c4, p4, lat);
            check("nb1_roundtrip", 64'(p4), 64'(d4));
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
